// File: rtl/param_lifo.sv
// Parameterized register-file LIFO: a pointer equal to count addresses the stack, and dOut shows the top entry.
// Define LIFO_ERR_FLAGS_EN to get sticky ovf/unf flags; when it is undefined both flags are tied low.
module param_lifo #(
  parameter int BITWIDTH = 5,
  parameter int DEPTH    = 4,
  parameter int AF_LEVEL = 12
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                wEn,
  input  logic                rEn,
  input  logic [BITWIDTH-1:0] dIn,
  output logic [BITWIDTH-1:0] dOut,
  output logic [DEPTH:0]      count,
  output logic                full,
  output logic                empty,
  output logic                almostFull,
  input  logic                errClr,
  output logic                ovf,
  output logic                unf
);
  localparam int NUM = 2 ** DEPTH;
  localparam logic [DEPTH:0] NUM_C = (DEPTH+1)'(NUM);
  localparam logic [DEPTH:0] AF_C  = (DEPTH+1)'(AF_LEVEL);
  localparam logic [DEPTH:0] ONE_C = (DEPTH+1)'(1);

  logic [NUM-1:0][BITWIDTH-1:0] mem_q, mem_d;
  logic [DEPTH:0]               cnt_q, cnt_d;
  logic [DEPTH-1:0]             top_idx, wr_idx;
  logic                         ovf_evt, unf_evt;

  assign full       = (cnt_q == NUM_C);
  assign empty      = (cnt_q == '0);
  assign almostFull = (cnt_q >= AF_C);
  assign count      = cnt_q;
  // When full the low bits wrap to 0, so top_idx lands on the last entry.
  assign top_idx    = cnt_q[DEPTH-1:0] - 1'b1;
  assign wr_idx     = cnt_q[DEPTH-1:0];
  assign dOut       = empty ? '0 : mem_q[top_idx];

  always_comb begin
    cnt_d   = cnt_q;
    mem_d   = mem_q;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    unique case ({wEn, rEn})
      2'b10: begin
        if (!full) begin
          mem_d[wr_idx] = dIn;
          cnt_d         = cnt_q + ONE_C;
        end else begin
          ovf_evt = 1'b1;
        end
      end
      2'b01: begin
        if (!empty) cnt_d = cnt_q - ONE_C;
        else        unf_evt = 1'b1;
      end
      2'b11: begin
        // Simultaneous push+pop replaces the top; on an empty stack it is a plain push.
        if (empty) begin
          mem_d[0] = dIn;
          cnt_d    = ONE_C;
        end else begin
          mem_d[top_idx] = dIn;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Storage is never reset; dOut is gated by empty so stale data stays hidden.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

`ifdef LIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d, unf_q, unf_d;

  always_comb begin
    ovf_d = errClr ? 1'b0 : (ovf_q | ovf_evt);
    unf_d = errClr ? 1'b0 : (unf_q | unf_evt);
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ovf = ovf_q;
  assign unf = unf_q;
`else
  logic unused_err;
  assign unused_err = ^{errClr, ovf_evt, unf_evt};
  assign ovf = 1'b0;
  assign unf = 1'b0;
`endif

endmodule
